reg_file_sequencer: RTL and testbench

- Multi-cycle control FSM that sequences one 8-bit register-to-register instruction at a time through reg_file and the ALU.
- Accepts an instruction over a valid/ready handshake and drives the reg_file read addresses, ALU select, write address, write data and write enable.
- Sits between the instruction source (testbench or instruction memory) and the reg_file/ALU datapath in the basic computer organization top level.

---
 rtl/seq_pkg.sv | 38 +++
 rtl/reg_file_sequencer.sv | 97 +++++++++
 tb/tb_reg_file_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared constants for the register-file instruction sequencer: widths, opcodes, FSM encoding, field positions.
// Pure definitions: no logic, no latency, no backpressure.
package seq_pkg;

    localparam int SEQ_DATA_W  = 8;
    localparam int SEQ_ADDR_W  = 2;
    localparam int SEQ_OPC_W   = 2;
    localparam int SEQ_CNT_W   = 8;
    localparam int SEQ_INSTR_W = SEQ_OPC_W + 3 * SEQ_ADDR_W;

    localparam logic [SEQ_OPC_W-1:0] OP_ADD = 2'b00;
    localparam logic [SEQ_OPC_W-1:0] OP_SUB = 2'b01;
    localparam logic [SEQ_OPC_W-1:0] OP_AND = 2'b10;
    localparam logic [SEQ_OPC_W-1:0] OP_MOV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } seq_state_t;

    // Instruction layout: [7:6] opcode, [5:4] rd, [3:2] rs1, [1:0] rs2
    localparam int OPC_LSB = 3 * SEQ_ADDR_W;
    localparam int RD_LSB  = 2 * SEQ_ADDR_W;
    localparam int RS1_LSB = SEQ_ADDR_W;
    localparam int RS2_LSB = 0;

    function automatic logic [SEQ_INSTR_W-1:0] make_instr(
        input logic [SEQ_OPC_W-1:0]  opc,
        input logic [SEQ_ADDR_W-1:0] rd,
        input logic [SEQ_ADDR_W-1:0] rs1,
        input logic [SEQ_ADDR_W-1:0] rs2
    );
        return {opc, rd, rs1, rs2};
    endfunction

endpackage

// File: rtl/reg_file_sequencer.sv
// Four-phase FSM (IDLE/READ/EXEC/WB) driving one reg-to-reg instruction through reg_file and ALU; write-back 3 edges after accept.
// Backpressure: instr_ready only in IDLE with run high, so one instruction per 4 cycles; held-off instructions stay with the source.
module reg_file_sequencer
    import seq_pkg::*;
#(
    parameter int DATA_W = SEQ_DATA_W,
    parameter int ADDR_W = SEQ_ADDR_W,
    parameter int OPC_W  = SEQ_OPC_W,
    parameter int CNT_W  = SEQ_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run,
    input  logic [OPC_W+3*ADDR_W-1:0]   instr,
    input  logic                        instr_valid,
    output logic                        instr_ready,
    input  logic [DATA_W-1:0]           alu_result,
    output logic [OPC_W-1:0]            alu_sel,
    output logic [ADDR_W-1:0]           reg_read_add1,
    output logic [ADDR_W-1:0]           reg_read_add2,
    output logic [ADDR_W-1:0]           reg_write_add,
    output logic [DATA_W-1:0]           reg_write_data,
    output logic                        write_en,
    output logic                        busy,
    output logic                        done,
    output logic [CNT_W-1:0]            instr_count
);

    localparam int INSTR_W = OPC_W + 3 * ADDR_W;
    localparam int F_RS2   = 0;
    localparam int F_RS1   = ADDR_W;
    localparam int F_RD    = 2 * ADDR_W;
    localparam int F_OPC   = 3 * ADDR_W;

    seq_state_t           state_q, state_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]    res_q, res_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid && run) begin
                    ir_d    = instr;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // Operands were presented in READ; capture before rd may be overwritten.
                res_d   = alu_result;
                state_d = ST_WB;
            end
            ST_WB: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // IR is held after write-back so addresses stay stable through the following IDLE.
    assign alu_sel        = ir_q[F_OPC +: OPC_W];
    assign reg_read_add1  = ir_q[F_RS1 +: ADDR_W];
    assign reg_read_add2  = ir_q[F_RS2 +: ADDR_W];
    assign reg_write_add  = ir_q[F_RD  +: ADDR_W];
    assign reg_write_data = res_q;

    assign instr_ready = (state_q == ST_IDLE) && run;
    assign busy        = (state_q != ST_IDLE);
    assign write_en    = (state_q == ST_WB);
    assign done        = (state_q == ST_WB);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Bench: reg file + ALU environment around the sequencer, cycle-level reference model, directed and random stimulus.
module tb_reg_file_sequencer;
    import seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [7:0] alu_result;
    logic [1:0] alu_sel;
    logic [1:0] reg_read_add1, reg_read_add2, reg_write_add;
    logic [7:0] reg_write_data;
    logic       write_en, busy, done;
    logic [7:0] instr_count;

    always #5 clk = ~clk;

    reg_file_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_result(alu_result), .alu_sel(alu_sel),
        .reg_read_add1(reg_read_add1), .reg_read_add2(reg_read_add2),
        .reg_write_add(reg_write_add), .reg_write_data(reg_write_data),
        .write_en(write_en), .busy(busy), .done(done), .instr_count(instr_count)
    );

    function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            default: return a;
        endcase
    endfunction

    // Environment: register file and ALU the sequencer controls
    logic [7:0] regs [4];
    logic       pl_vld = 1'b0;
    logic [1:0] pl_a = 2'd0;
    logic [7:0] pl_d = 8'h00;

    always_comb alu_result = alu_f(alu_sel, regs[reg_read_add1], regs[reg_read_add2]);

    always @(posedge clk) begin
        if (write_en)    regs[reg_write_add] <= reg_write_data;
        else if (pl_vld) regs[pl_a] <= pl_d;
    end

    // Reference model: age = cycles since acceptance (0 = no instruction in flight)
    int         age = 0;
    logic [7:0] m_ir = 8'h00;
    logic [7:0] m_res = 8'h00;
    logic [7:0] m_cnt = 8'h00;
    logic [7:0] mregs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    int         acc_n = 0;
    int         ret_n = 0;
    int         cyc = 0;
    int         acc_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            age   = 0;
            m_ir  = 8'h00;
            m_res = 8'h00;
            m_cnt = 8'h00;
        end else begin
            if (age == 0) begin
                if (instr_valid && run) begin
                    m_ir = instr;
                    age  = 1;
                    acc_n++;
                    acc_cyc.push_back(cyc);
                end
            end else if (age == 1) begin
                age = 2;
            end else if (age == 2) begin
                m_res = alu_f(m_ir[7:6], mregs[m_ir[3:2]], mregs[m_ir[1:0]]);
                age   = 3;
            end else begin
                mregs[m_ir[5:4]] = m_res;
                m_cnt = m_cnt + 8'd1;
                ret_n++;
                age = 0;
            end
            if (pl_vld) mregs[pl_a] = pl_d;
        end
    end

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    bit regs_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: timeout waiting for DUT at cycle %0d", nm, cyc);
    endtask

    // Per-cycle compare against the model
    always begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            chk("busy",        busy,           age != 0);
            chk("write_en",    write_en,       age == 3);
            chk("done",        done,           age == 3);
            chk("instr_ready", instr_ready,    (age == 0) && run);
            chk("instr_count", instr_count,    m_cnt);
            chk("alu_sel",     alu_sel,        m_ir[7:6]);
            chk("rd_add1",     reg_read_add1,  m_ir[3:2]);
            chk("rd_add2",     reg_read_add2,  m_ir[1:0]);
            chk("wr_add",      reg_write_add,  m_ir[5:4]);
            chk("wr_data",     reg_write_data, m_res);
            if (regs_en) begin
                for (int i = 0; i < 4; i++) chk($sformatf("reg%0d", i), regs[i], mregs[i]);
            end
        end
    end

    task automatic preload(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_vld = 1'b1; pl_a = a; pl_d = d;
        @(negedge clk);
        pl_vld = 1'b0;
    endtask

    task automatic wait_acc(input int a0, input string nm);
        int n;
        n = 0;
        while (acc_n == a0 && n < 100) begin @(negedge clk); n++; end
        if (acc_n == a0) timeout(nm);
    endtask

    task automatic wait_ret(input int target, input string nm);
        int n;
        n = 0;
        while (ret_n < target && n < 2000) begin @(negedge clk); n++; end
        if (ret_n < target) timeout(nm);
    endtask

    task automatic issue(input logic [7:0] ins, input string nm);
        int a0, r0;
        a0 = acc_n;
        r0 = ret_n;
        @(negedge clk);
        instr = ins; instr_valid = 1'b1;
        wait_acc(a0, nm);
        instr_valid = 1'b0;
        wait_ret(r0 + 1, nm);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int a0, r0, aq;
        run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   busy, 0);
        chk("rst_we",     write_en, 0);
        chk("rst_done",   done, 0);
        chk("rst_count",  instr_count, 0);
        chk("rst_sel",    alu_sel, 0);
        chk("rst_wdata",  reg_write_data, 0);
        chk("rst_ready",  instr_ready, 1);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        preload(2'd0, 8'hAA);
        preload(2'd1, 8'h55);
        preload(2'd2, 8'h00);
        preload(2'd3, 8'h00);
        regs_en = 1'b1;

        // ADD r2 = r0 + r1; write-back 3 edges after acceptance
        aq = acc_cyc.size();
        issue(make_instr(OP_ADD, 2'd2, 2'd0, 2'd1), "add");
        chk("add_r2", regs[2], 8'hFF);
        chk("add_cnt", instr_count, 8'd1);

        do_reset();
        issue(make_instr(OP_SUB, 2'd3, 2'd0, 2'd1), "sub");
        chk("sub_r3", regs[3], 8'h55);
        issue(make_instr(OP_AND, 2'd2, 2'd0, 2'd1), "and");
        chk("and_r2", regs[2], 8'h00);
        chk("and_cnt", instr_count, 8'd2);

        // Back-to-back: valid held for three acceptances
        aq = acc_cyc.size();
        a0 = acc_n;
        r0 = ret_n;
        @(negedge clk);
        instr = make_instr(OP_MOV, 2'd3, 2'd1, 2'd0); instr_valid = 1'b1;
        wait_acc(a0, "b2b_1");
        wait_acc(a0 + 1, "b2b_2");
        wait_acc(a0 + 2, "b2b_3");
        instr_valid = 1'b0;
        wait_ret(r0 + 3, "b2b_ret");
        if (acc_cyc.size() >= aq + 3) begin
            chk("b2b_gap1", acc_cyc[aq+1] - acc_cyc[aq], 4);
            chk("b2b_gap2", acc_cyc[aq+2] - acc_cyc[aq+1], 4);
        end else begin
            timeout("b2b_gaps");
        end
        chk("mov_r3", regs[3], 8'h55);
        chk("mov_cnt", instr_count, 8'd5);

        // Hazard: r0 = r0 + r0
        issue(make_instr(OP_ADD, 2'd0, 2'd0, 2'd0), "hazard");
        chk("hazard_r0", regs[0], 8'h54);

        // Reset during EXEC aborts the write to r1
        a0 = acc_n;
        @(negedge clk);
        instr = make_instr(OP_SUB, 2'd1, 2'd0, 2'd0); instr_valid = 1'b1;
        wait_acc(a0, "abort_acc");
        instr_valid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_we",   write_en, 0);
        chk("abort_cnt",  instr_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("abort_r1", regs[1], 8'h55);

        // run=0 holds off a valid instruction without losing it
        @(negedge clk);
        run = 1'b0;
        instr = make_instr(OP_MOV, 2'd2, 2'd1, 2'd0); instr_valid = 1'b1;
        repeat (6) @(negedge clk);
        chk("hold_ready", instr_ready, 0);
        chk("hold_busy",  busy, 0);
        chk("hold_cnt",   instr_count, 0);
        a0 = acc_n;
        r0 = ret_n;
        run = 1'b1;
        wait_acc(a0, "hold_acc");
        instr_valid = 1'b0;
        wait_ret(r0 + 1, "hold_ret");
        @(negedge clk);
        chk("hold_r2",  regs[2], 8'h55);
        chk("hold_cnt1", instr_count, 8'd1);

        // Random: 256 retirements with run toggling; counter returns to 0
        do_reset();
        r0 = ret_n;
        for (int n = 0; n < 256; n++) begin
            int k;
            k = $urandom_range(0, 2);
            repeat (k) begin @(negedge clk); run = ($urandom_range(0, 3) != 0); end
            @(negedge clk);
            a0 = acc_n;
            instr = 8'($urandom);
            instr_valid = 1'b1;
            k = 0;
            while (acc_n == a0 && k < 200) begin
                @(negedge clk);
                run = ($urandom_range(0, 3) != 0);
                k++;
            end
            if (acc_n == a0) timeout("rand_acc");
            instr_valid = 1'b0;
        end
        run = 1'b1;
        wait_ret(r0 + 256, "rand_ret");
        @(negedge clk);
        chk("wrap_cnt", instr_count, 8'd0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
